biquad_coeff_sequencer: RTL and testbench

- Wishbone master that loads biquad coefficient batches into the two-stage biquad chain's 8-bit WB coefficient space.
- Takes (address, data, last) write commands from a valid/ready stream.
- Issues single WB writes with retry and timeout handling.
- After a clean batch, pulses the biquad reset so new coefficients take effect from a known state. Sits between the housekeeping command path and the chain's WB target port.

---
 rtl/biquad_coeff_sequencer.sv | 158 +++++++++++++++
 tb/tb_biquad_coeff_sequencer.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/biquad_coeff_sequencer.sv
// biquad_coeff_sequencer: WB master loading biquad coefficient batches, then pulsing the chain reset.
// Define BQ_SEQ_READBACK_EN to verify every write with a read of the same address.
module biquad_coeff_sequencer #(
  parameter int ADR_W      = 8,
  parameter int TIMEOUT    = 255,
  parameter int MAX_RETRY  = 3,
  parameter int RST_CYCLES = 16
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [ADR_W-1:0] cmd_adr_i,
  input  logic [31:0]      cmd_dat_i,
  input  logic             cmd_last_i,
  output logic             wb_cyc_o,
  output logic             wb_stb_o,
  output logic             wb_we_o,
  output logic [ADR_W-1:0] wb_adr_o,
  output logic [31:0]      wb_dat_o,
  output logic [3:0]       wb_sel_o,
  input  logic [31:0]      wb_dat_i,
  input  logic             wb_ack_i,
  input  logic             wb_err_i,
  input  logic             wb_rty_i,
  output logic             bq_reset_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             error_o,
  output logic [15:0]      wr_count_o
);
  typedef enum logic [2:0] {IDLE, ISSUE, RETRY, DRAIN, RSTP, DONE, RDBK} state_e;
  localparam logic [15:0] TMO_L = 16'(TIMEOUT);
  localparam logic [15:0] RST_L = 16'(RST_CYCLES);
  localparam logic [15:0] MR_L  = 16'(MAX_RETRY);
  state_e           state_q, state_d;
  logic [ADR_W-1:0] adr_q, adr_d;
  logic [31:0]      dat_q, dat_d;
  logic [15:0]      tmo_q, tmo_d, att_q, att_d, cnt_q, cnt_d, cnt_inc;
  logic             last_q, last_d, busy_q, busy_d, err_q, err_d, rdy_q, rdy_d;
  logic             hs, fail, bus_act;
  assign hs      = cmd_valid_i & rdy_q;
  assign fail    = wb_err_i | wb_rty_i | (tmo_q == TMO_L - 16'd1);
  assign cnt_inc = cnt_q + {15'd0, ~&cnt_q};
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      adr_q   <= '0;
      dat_q   <= '0;
      tmo_q   <= '0;
      att_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      adr_q   <= adr_d;
      dat_q   <= dat_d;
      tmo_q   <= tmo_d;
      att_q   <= att_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    adr_d   = adr_q;
    dat_d   = dat_q;
    tmo_d   = tmo_q;
    att_d   = att_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    busy_d  = busy_q;
    err_d   = err_q;
    case (state_q)
      IDLE: if (hs) begin
        adr_d   = cmd_adr_i;
        dat_d   = cmd_dat_i;
        last_d  = cmd_last_i;
        att_d   = '0;
        tmo_d   = '0;
        busy_d  = 1'b1;
        cnt_d   = busy_q ? cnt_q : '0;
        state_d = ISSUE;
      end
      ISSUE: begin
        tmo_d = tmo_q + 16'd1;
`ifdef BQ_SEQ_READBACK_EN
        if (wb_ack_i) begin
          tmo_d   = '0;
          state_d = RDBK;
        end else if (fail) state_d = RETRY;
`else
        if (wb_ack_i) begin
          tmo_d   = '0;
          cnt_d   = cnt_inc;
          state_d = last_q ? RSTP : IDLE;
        end else if (fail) state_d = RETRY;
`endif
      end
`ifdef BQ_SEQ_READBACK_EN
      RDBK: begin
        tmo_d = tmo_q + 16'd1;
        if (wb_ack_i && wb_dat_i == dat_q) begin
          tmo_d   = '0;
          cnt_d   = cnt_inc;
          state_d = last_q ? RSTP : IDLE;
        end else if (wb_ack_i || fail) state_d = RETRY;
      end
`endif
      RETRY: if (att_q < MR_L) begin
        att_d   = att_q + 16'd1;
        tmo_d   = '0;
        state_d = ISSUE;
      end else begin
        err_d   = 1'b1;
        state_d = last_q ? DONE : DRAIN;
      end
      DRAIN: state_d = (hs && cmd_last_i) ? DONE : DRAIN;
      RSTP: begin
        tmo_d   = tmo_q + 16'd1;
        state_d = (tmo_q == RST_L - 16'd1) ? DONE : RSTP;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == DONE) ? 1'b0 : busy_d;
    // Registered ready stays low for the first cycle after reset.
    rdy_d  = (state_d == IDLE) || (state_d == DRAIN);
  end
  always_comb begin
    bus_act    = (state_q == ISSUE) || (state_q == RDBK);
    wb_cyc_o   = bus_act;
    wb_stb_o   = bus_act;
`ifdef BQ_SEQ_READBACK_EN
    wb_we_o    = state_q == ISSUE;
`else
    wb_we_o    = 1'b1;
`endif
    bq_reset_o = state_q == RSTP;
    done_o     = state_q == DONE;
  end
`ifndef BQ_SEQ_READBACK_EN
  logic unused_rd;
  assign unused_rd = ^wb_dat_i;
`endif
  assign cmd_ready_o = rdy_q;
  assign wb_adr_o    = adr_q;
  assign wb_dat_o    = dat_q;
  assign wb_sel_o    = 4'hF;
  assign busy_o      = busy_q;
  assign error_o     = err_q;
  assign wr_count_o  = cnt_q;
endmodule

// File: tb/tb_biquad_coeff_sequencer.sv
// tb_biquad_coeff_sequencer: scripted WB slave plus attempt-level reference model for the sequencer.
module tb_biquad_coeff_sequencer;
  localparam int TMO = 255;
  localparam int MRT = 3;
  localparam int RSTC = 16;
  localparam int ACK = 0, ERR = 1, RTY = 2, NONE = 3, ACKRTY = 4;
  typedef struct packed {logic [2:0] code; logic [1:0] dly;} resp_t;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_last = 0;
  logic [7:0] cmd_adr = 0;
  logic [31:0] cmd_dat = 0, wb_dat_in = 0;
  logic wb_ack = 0, wb_err = 0, wb_rty = 0;
  logic cmd_ready_o, wb_cyc_o, wb_stb_o, wb_we_o, bq_reset_o, busy_o, done_o, error_o;
  logic [7:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0] wb_sel_o;
  logic [15:0] wr_count_o;
  int total = 0, bad = 0;
  resp_t plan[$], sq[$];
  logic [7:0] b_adr[$];
  logic [31:0] b_dat[$];
  logic [31:0] xq[$];
  logic [7:0] seen_adr[$];
  logic [31:0] seen_dat[$];
  logic seen_we[$];
  int seen_len[$];
  int rst_len = 0, done_cnt = 0, cur_len = 0;
  logic stb_p = 0;
  bit err_exp = 0;
  logic [31:0] mem [256];

  biquad_coeff_sequencer dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_last_i(cmd_last),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_dat_i(wb_dat_in), .wb_ack_i(wb_ack),
    .wb_err_i(wb_err), .wb_rty_i(wb_rty), .bq_reset_o(bq_reset_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .wr_count_o(wr_count_o)
  );

  always #5 clk = ~clk;

  // Slave: each strobe burst pops one scripted response, fired dly cycles into the burst.
  bit act = 0;
  int sc = 0;
  resp_t cr;
  always @(negedge clk) begin
    wb_ack = 0;
    wb_err = 0;
    wb_rty = 0;
    if (wb_stb_o && !rst) begin
      if (!act) begin
        act = 1;
        sc = 0;
        if (sq.size() > 0) cr = sq.pop_front();
        else begin
          cr.code = 3'(NONE);
          cr.dly = 0;
        end
      end else sc++;
      if (sc == int'(cr.dly)) begin
        wb_ack = (cr.code == 3'(ACK)) || (cr.code == 3'(ACKRTY));
        wb_err = cr.code == 3'(ERR);
        wb_rty = (cr.code == 3'(RTY)) || (cr.code == 3'(ACKRTY));
        if (wb_ack && wb_we_o) mem[wb_adr_o] = wb_dat_o;
        if (wb_ack && !wb_we_o) wb_dat_in = mem[wb_adr_o] ^ ((xq.size() > 0) ? xq.pop_front() : 32'h0);
      end
    end else act = 0;
  end

  always @(negedge clk) begin
    if (wb_stb_o) begin
      if (!stb_p) begin
        seen_adr.push_back(wb_adr_o);
        seen_dat.push_back(wb_dat_o);
        seen_we.push_back(wb_we_o);
        cur_len = 0;
      end
      cur_len++;
    end else if (stb_p) seen_len.push_back(cur_len);
    stb_p = wb_stb_o;
    if (bq_reset_o) rst_len++;
    if (done_o) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [31:0] d, input logic l);
    int t = 0;
    cmd_valid = 1;
    cmd_adr = a;
    cmd_dat = d;
    cmd_last = l;
    while (!cmd_ready_o && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("cmd_ready_seen", cmd_ready_o, 1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done_o && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done_o, 1);
    chk("busy_at_done", busy_o, 0);
    repeat (3) @(negedge clk);
  endtask

  // Model: attempts per command until an ack or MAX_RETRY+1 failures; a failure drains the batch.
  task automatic run_batch(input string tag);
    logic [7:0] ea[$];
    logic [31:0] ed[$];
    int el[$];
    int pi = 0, cnt = 0;
    bit failed = 0;
    resp_t r;
    for (int i = 0; i < b_adr.size(); i++) begin
      if (!failed) begin
        for (int a = 0; a <= MRT; a++) begin
          if (pi < plan.size()) r = plan[pi];
          else begin
            r.code = 3'(NONE);
            r.dly = 0;
          end
          pi++;
          ea.push_back(b_adr[i]);
          ed.push_back(b_dat[i]);
          el.push_back(r.code == 3'(NONE) ? TMO : int'(r.dly) + 1);
          if (r.code == 3'(ACK) || r.code == 3'(ACKRTY)) begin
            cnt++;
            break;
          end
          if (a == MRT) failed = 1;
        end
      end
    end
    err_exp = err_exp | failed;
    seen_adr.delete();
    seen_dat.delete();
    seen_we.delete();
    seen_len.delete();
    rst_len = 0;
    done_cnt = 0;
    sq = plan;
    for (int i = 0; i < b_adr.size(); i++) send(b_adr[i], b_dat[i], i == b_adr.size() - 1);
    wait_done();
    chk({tag, "_strobes"}, seen_adr.size(), ea.size());
    for (int i = 0; i < ea.size() && i < seen_adr.size(); i++) begin
      chk({tag, "_adr"}, seen_adr[i], ea[i]);
      chk({tag, "_dat"}, seen_dat[i], ed[i]);
      chk({tag, "_we"}, seen_we[i], 1);
      if (i < seen_len.size()) chk({tag, "_stb_len"}, seen_len[i], el[i]);
    end
    chk({tag, "_wr_count"}, wr_count_o, cnt);
    chk({tag, "_error"}, error_o, err_exp);
    chk({tag, "_rst_len"}, rst_len, failed ? 0 : RSTC);
    chk({tag, "_done_cnt"}, done_cnt, 1);
    plan.delete();
    b_adr.delete();
    b_dat.delete();
  endtask

  function automatic resp_t mk(input int c, input int d);
    resp_t r;
    r.code = 3'(c);
    r.dly = 2'(d);
    return r;
  endfunction

  initial begin
    int t;
    repeat (3) @(negedge clk);
    chk("rst_cyc", wb_cyc_o, 0);
    chk("rst_stb", wb_stb_o, 0);
    chk("rst_sel", wb_sel_o, 4'hF);
    chk("rst_ready", cmd_ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_error", error_o, 0);
    chk("rst_count", wr_count_o, 0);
    chk("rst_bqrst", bq_reset_o, 0);
    chk("rst_adr", wb_adr_o, 0);
    rst = 0;
    @(negedge clk);
    chk("idle_ready", cmd_ready_o, 1);
`ifdef BQ_SEQ_READBACK_EN
    plan = '{mk(ACK, 1), mk(ACK, 1), mk(ACK, 1), mk(ACK, 1)};
    xq = '{32'h1, 32'h0};
    sq = plan;
    seen_we.delete();
    seen_adr.delete();
    rst_len = 0;
    send(8'h10, 32'hABCD, 1);
    wait_done();
    chk("rb_strobes", seen_we.size(), 4);
    for (int i = 0; i < 4 && i < seen_we.size(); i++) begin
      chk("rb_we", seen_we[i], (i % 2 == 0) ? 1 : 0);
      chk("rb_adr", seen_adr[i], 8'h10);
    end
    chk("rb_count", wr_count_o, 1);
    chk("rb_error", error_o, 0);
    chk("rb_rst_len", rst_len, RSTC);
`else
    b_adr = '{8'h00, 8'h04, 8'h84};
    b_dat = '{32'h11, 32'h22, 32'h33};
    plan = '{mk(ACK, 1), mk(ACK, 1), mk(ACK, 1)};
    run_batch("t1");
    b_adr = '{8'h08};
    b_dat = '{32'h44};
    plan = '{mk(ERR, 0), mk(ERR, 1), mk(ACK, 1)};
    run_batch("t2");
    b_adr = '{8'h0C};
    b_dat = '{32'h55};
    plan = '{mk(ACKRTY, 1)};
    run_batch("t4");
    b_adr = '{8'h88, 8'h8C, 8'h90};
    b_dat = '{32'h66, 32'h77, 32'h88};
    plan = '{mk(NONE, 0), mk(NONE, 0), mk(NONE, 0), mk(NONE, 0)};
    run_batch("t3");
    b_adr = '{8'h14};
    b_dat = '{32'h99};
    plan = '{mk(ACK, 0)};
    run_batch("sticky");
    // Reset in the 5th cycle of the chain-reset pulse.
    sq = '{mk(ACK, 0)};
    send(8'h20, 32'h5, 1);
    t = 0;
    while (!bq_reset_o && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("t5_pulse_seen", bq_reset_o, 1);
    repeat (4) @(negedge clk);
    chk("t5_busy_pre", busy_o, 1);
    rst = 1;
    @(negedge clk);
    chk("t5_bqrst", bq_reset_o, 0);
    chk("t5_busy", busy_o, 0);
    chk("t5_ready", cmd_ready_o, 0);
    chk("t5_error", error_o, 0);
    chk("t5_count", wr_count_o, 0);
    rst = 0;
    err_exp = 0;
    @(negedge clk);
    chk("t5_ready_idle", cmd_ready_o, 1);
    for (int b = 0; b < 8; b++) begin
      int n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) begin
        b_adr.push_back(8'($urandom));
        b_dat.push_back($urandom);
      end
      for (int k = 0; k < n * 4; k++) begin
        int v = $urandom_range(0, 19);
        plan.push_back(mk(v == 0 ? NONE : v < 3 ? ERR : v < 5 ? RTY : v < 7 ? ACKRTY : ACK, $urandom_range(0, 2)));
      end
      run_batch("rnd");
    end
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
